// File: rtl/imem_responder.sv
// imem_responder: tagged fixed-latency instruction memory model.
// Ports: clock/reset (async, active-low), mem_req, current_req_tag,
//   return_data, return_data_tag, preload_en/idx/data, optional stall.
//   Build macro IMEM_RESPONDER_STALL_EN adds the stall input.
package imem_pkg;
  localparam int TAG_W = 4;
  typedef logic [TAG_W-1:0] MEM_TAG;
  typedef logic [63:0] MEM_BLOCK;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ADDR_PACKET;
endpackage

module imem_responder
  import imem_pkg::*;
#(
  parameter int NUM_TAGS = 15,
  parameter int LATENCY  = 10,
  parameter int DEPTH    = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  input  ADDR_PACKET               mem_req,
  output MEM_TAG                   current_req_tag,
  output MEM_BLOCK                 return_data,
  output MEM_TAG                   return_data_tag,
  input  logic                     preload_en,
  input  logic [$clog2(DEPTH)-1:0] preload_idx,
  input  MEM_BLOCK                 preload_data
`ifdef IMEM_RESPONDER_STALL_EN
  ,
  input  logic                     stall
`endif
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
  localparam int CW = 7;

  logic stall_i;
`ifdef IMEM_RESPONDER_STALL_EN
  assign stall_i = stall;
`else
  assign stall_i = 1'b0;
`endif

  MEM_BLOCK            mem [DEPTH];
  logic [NUM_TAGS-1:0] free_q;
  MEM_TAG              f_tag [NUM_TAGS];
  logic [IW-1:0]       f_idx [NUM_TAGS];
  logic [CW-1:0]       f_cnt [NUM_TAGS];
  logic [NUM_TAGS-1:0] f_vld;
  logic [PW-1:0]       rd_ptr;
  logic [PW-1:0]       wr_ptr;

  MEM_TAG        grant;
  MEM_TAG        head_bit;
  logic          accept;
  logic          ret;
  logic [IW-1:0] req_idx;

  logic unused_addr_bits;
  assign unused_addr_bits =
    ^{mem_req.addr[2:0], mem_req.addr[31:3+IW]};

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(NUM_TAGS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign req_idx = mem_req.addr[3 +: IW];

  // lowest-numbered free tag wins
  always_comb begin
    grant = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (free_q[i]) grant = MEM_TAG'(i + 1);
    end
  end

  // a tag freed by this cycle's return is not yet in free_q
  assign accept = reset && mem_req.valid && !stall_i
                  && (grant != '0);
  assign current_req_tag = accept ? grant : '0;

  assign ret = f_vld[rd_ptr] && (f_cnt[rd_ptr] <= CW'(1))
               && !stall_i;
  assign head_bit = f_tag[rd_ptr] - 1'b1;

  // storage is read in the return cycle, before any preload lands
  assign return_data_tag = ret ? f_tag[rd_ptr] : '0;
  assign return_data     = ret ? mem[f_idx[rd_ptr]] : '0;

  always_ff @(posedge clock) begin
    if (preload_en) mem[preload_idx] <= preload_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      free_q <= '1;
      f_vld  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < NUM_TAGS; i++) begin
        f_tag[i] <= '0;
        f_idx[i] <= '0;
        f_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        if (f_vld[i] && f_cnt[i] != '0 && !stall_i)
          f_cnt[i] <= f_cnt[i] - 1'b1;
      end
      if (ret) begin
        f_vld[rd_ptr]    <= 1'b0;
        free_q[head_bit] <= 1'b1;
        rd_ptr           <= nxt(rd_ptr);
      end
      if (accept) begin
        f_vld[wr_ptr]          <= 1'b1;
        f_tag[wr_ptr]          <= grant;
        f_idx[wr_ptr]          <= req_idx;
        f_cnt[wr_ptr]          <= CW'(LATENCY);
        free_q[grant - 1'b1]   <= 1'b0;
        wr_ptr                 <= nxt(wr_ptr);
      end
    end
  end

endmodule
